// File: rtl/reg_cpu_arb.sv
// reg_cpu_arb: round-robin arbiter sequencing NREQ requesters onto one register CPU bus
module reg_cpu_arb #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               reg_cpu_clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic               rsp_err,
  output logic [DW-1:0]      rsp_rdata,
  output logic               busy,
  output logic               reg_cpu_cs,
  output logic [AW-1:0]      reg_cpu_addr,
  output logic [DW-1:0]      reg_cpu_wr_data,
  output logic               reg_cpu_we,
  output logic               reg_cpu_re,
  input  logic [DW-1:0]      reg_cpu_rd_data,
  input  logic               reg_cpu_wack,
  input  logic               reg_cpu_rdv
);
  localparam int LW = $clog2(NREQ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] last_q, last_d, gnt_q, gnt_d, win, cand;
  logic found, ack, tmo;
  logic txn_we_q, txn_we_d, cs_q, cs_d, we_q, we_d, re_q, re_d, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [NREQ-1:0] rsp_q, rsp_d;
  // Rotating search starting just after the last granted requester
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k >= NREQ) ? LW'(int'(last_q) + k - NREQ) : LW'(int'(last_q) + k);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
  assign req_ready = (state_q == IDLE && found && !rst) ? NREQ'(1) << win : '0;
  assign ack = txn_we_q ? reg_cpu_wack : reg_cpu_rdv;
  assign tmo = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    txn_we_d = txn_we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    cs_d     = cs_q;
    we_d     = we_q;
    re_d     = re_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rsp_d    = '0;
    unique case (state_q)
      IDLE: if (found) begin
        state_d  = ACCESS;
        last_d   = win;
        gnt_d    = win;
        txn_we_d = req_we[win];
        addr_d   = req_addr[int'(win)*AW +: AW];
        wdata_d  = req_wdata[int'(win)*DW +: DW];
        cnt_d    = '0;
        cs_d     = 1'b1;
        we_d     = req_we[win];
        re_d     = !req_we[win];
      end
      ACCESS: if (ack || tmo) begin
        state_d = RESP;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        rsp_d   = NREQ'(1) << gnt_q;
        err_d   = !ack;
        rdata_d = (ack && !txn_we_q) ? reg_cpu_rd_data : '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge reg_cpu_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= LW'(NREQ - 1);
      gnt_q    <= '0;
      txn_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      txn_we_q <= txn_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      re_q     <= re_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rsp_q    <= rsp_d;
    end
  end
  assign busy            = state_q != IDLE;
  assign rsp_valid       = rsp_q;
  assign rsp_err         = err_q;
  assign rsp_rdata       = rdata_q;
  assign reg_cpu_cs      = cs_q;
  assign reg_cpu_we      = we_q;
  assign reg_cpu_re      = re_q;
  assign reg_cpu_addr    = addr_q;
  assign reg_cpu_wr_data = wdata_q;
endmodule
